op_phase_sequencer: RTL
=======================

// Module: op_phase_sequencer
// PURPOSE
// - Per-sample scheduler for the shared phase-increment datapath (fnum/mult/block -> phase_inc, 2-cycle latency).
// - On each sample_clk_en, sweeps every operator slot in order: bank 0 op 0..17, then bank 1 op 0..17.
// - Drives bank_num/op_num into the register file and phase datapath at a fixed issue spacing.
// - Re-emits the slot tag aligned to the datapath output so downstream NCO/accumulator writes land on the correct slot.
// PARAMETERS
// - NUM_BANKS    2   banks swept per sample
// - NUM_OPS      18  operators per bank
// - OP_SPACING   4   clocks between successive slot issues (>=1)
// - PIPE_DELAY   2   datapath latency from slot issue to phase_inc valid
// PORTS
// - clk            in   1               system clock
// - reset_n        in   1               asynchronous active-low reset
// - sample_clk_en  in   1               one-cycle pulse: start a new sweep
// - ovr_clr        in   1               clears sticky overrun
// - bank_num       out  BANK_NUM_WIDTH  slot bank to register file/datapath (p0)
// - op_num         out  OP_NUM_WIDTH    slot op to register file/datapath (p0)
// - issue_p0       out  1               bank_num/op_num valid this cycle
// - bank_num_p2    out  BANK_NUM_WIDTH  bank tag aligned with phase_inc_p2
// - op_num_p2      out  OP_NUM_WIDTH    op tag aligned with phase_inc_p2
// - valid_p2       out  1               phase_inc_p2 valid for tagged slot
// - busy           out  1               sweep or drain in progress
// - sweep_done     out  1               one-cycle pulse, last slot's result is out
// - overrun        out  1               sticky: sample_clk_en arrived while busy
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; counters 0; tag pipeline cleared.
// - FSM IDLE: sample_clk_en -> ISSUE at slot (0,0), busy=1 from next cycle.
// - ISSUE: issue_p0=1 for exactly one cycle with current slot; next state GAP if OP_SPACING>1, else stays ISSUE.
// - GAP: counts OP_SPACING-1 cycles, bank_num/op_num hold last issued slot, issue_p0=0; then ISSUE.
// - Slot advance after each issue: op+1; op==NUM_OPS-1 wraps op to 0, bank+1.
// - Issuing slot (NUM_BANKS-1, NUM_OPS-1) -> DRAIN instead of GAP/ISSUE.
// - DRAIN: waits PIPE_DELAY cycles, then sweep_done pulses in the cycle valid_p2 is high for the last slot; -> IDLE.
// - Tag pipeline: {issue_p0,bank,op} shifted PIPE_DELAY stages every clock; valid_p2/bank_num_p2/op_num_p2 are stage PIPE_DELAY.
// - Issue cadence: issue k at cycle T0+1+k*OP_SPACING (T0 = sample_clk_en cycle); valid_p2 at issue+PIPE_DELAY.
// - Sweep length: NUM_BANKS*NUM_OPS*OP_SPACING - OP_SPACING + 1 + PIPE_DELAY cycles to sweep_done (defaults: 143).
// - sample_clk_en while busy (incl. sweep_done cycle): ignored, overrun<=1; sweep continues unaffected.
// - sample_clk_en in IDLE cycle right after sweep_done: accepted normally.
// - ovr_clr and a new overrun in same cycle: overrun stays 1 (set wins).
// - busy=1 from cycle after accepted start through sweep_done cycle inclusive.
// - bank_num/op_num hold last slot in IDLE (no glitching of register reads).
// - reset_n mid-sweep: immediate abort, all state/tags cleared, no sweep_done.
// - Counter widths from package constants; no arithmetic overflow, explicit wrap compares only.
// STRUCTURE
// - Package opl3_pkg: BANK_NUM_WIDTH, OP_NUM_WIDTH, NUM_BANKS, NUM_OPERATORS_PER_BANK, PHASE_PIPE_DELAY, seq_state_t enum {IDLE,ISSUE,GAP,DRAIN}.
// - One sub-module: slot_tag_pipe (PIPE_DELAY-deep shift register of {valid,bank,op}, async reset).
// - FSM, spacing counter and slot counters live in the top module.
// TESTING
// - Reset then single sample_clk_en (defaults) -> 36 issue_p0 pulses 4 cycles apart, first at T0+1; sweep_done at T0+143.
// - Check alignment: valid_p2 exactly 2 cycles after each issue_p0; tag (1,17) is last; order (0,0)..(0,17),(1,0)..(1,17).
// - sample_clk_en at T0+50 -> overrun=1, issue sequence unchanged; ovr_clr -> overrun=0 next cycle.
// - OP_SPACING=1 -> 36 consecutive issue cycles, sweep_done at T0+38; no gap states visited.
// - reset_n low at T0+60 -> all outputs 0 within same cycle; no sweep_done; next start begins at (0,0).
// - sample_clk_en in cycle after sweep_done -> accepted, overrun stays 0, second sweep identical.

Source files
------------

// File: rtl/opl3_pkg.sv
// -----------------------------------------------------------------------------
// opl3_pkg
// Shared constants and types for the operator phase-increment scheduling logic.
//   - Slot geometry: NUM_BANKS banks of NUM_OPERATORS_PER_BANK operators.
//   - Tag widths used on every bank/op bus.
//   - Default issue spacing and phase datapath latency.
//   - seq_state_t: sequencer FSM states.
// -----------------------------------------------------------------------------
package opl3_pkg;

    localparam int unsigned NUM_BANKS              = 2;
    localparam int unsigned NUM_OPERATORS_PER_BANK = 18;
    localparam int unsigned PHASE_PIPE_DELAY       = 2;
    localparam int unsigned OP_ISSUE_SPACING       = 4;

    localparam int unsigned BANK_NUM_WIDTH = 1;
    localparam int unsigned OP_NUM_WIDTH   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/op_phase_sequencer_slot_tag_pipe.sv
// -----------------------------------------------------------------------------
// slot_tag_pipe
// Delay line carrying the {valid, bank, op} tag of each issued slot so that it
// emerges in the same cycle as the phase datapath result for that slot.
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset (clears all stages)
//   i_valid/i_bank/i_op  tag entering at the issue stage
//   o_valid/o_bank/o_op  tag after DEPTH clocks
// -----------------------------------------------------------------------------
module slot_tag_pipe
    import opl3_pkg::*;
#(
    parameter int unsigned DEPTH  = PHASE_PIPE_DELAY,
    parameter int unsigned BANK_W = BANK_NUM_WIDTH,
    parameter int unsigned OP_W   = OP_NUM_WIDTH
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic [BANK_W-1:0] i_bank,
    input  logic [OP_W-1:0]   i_op,
    output logic              o_valid,
    output logic [BANK_W-1:0] o_bank,
    output logic [OP_W-1:0]   o_op
);

    localparam int unsigned TAG_W = 1 + BANK_W + OP_W;

    logic [TAG_W-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= {i_valid, i_bank, i_op};
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign {o_valid, o_bank, o_op} = r_stage[DEPTH-1];

endmodule

// File: rtl/op_phase_sequencer.sv
// -----------------------------------------------------------------------------
// op_phase_sequencer
// Per-sample scheduler for the shared phase-increment datapath. Each accepted
// sample_clk_en sweeps every operator slot (bank 0 op 0..N-1, then bank 1 ...),
// issuing one slot every OP_SPACING clocks, and re-emits each slot tag
// PIPE_DELAY clocks later, aligned with the datapath's phase_inc result.
// Ports:
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_sample_clk_en          one-cycle start pulse for a new sweep
//   i_ovr_clr                clears the sticky overrun flag
//   o_bank_num, o_op_num     slot driven to register file / datapath (p0)
//   o_issue_p0               p0 slot is valid this cycle
//   o_bank_num_p2, o_op_num_p2, o_valid_p2   tag aligned to phase_inc_p2
//   o_busy                   sweep or drain in progress
//   o_sweep_done             pulses with the last slot's result
//   o_overrun                sticky: start requested while busy
// -----------------------------------------------------------------------------
module op_phase_sequencer #(
    parameter int unsigned NUM_BANKS  = opl3_pkg::NUM_BANKS,
    parameter int unsigned NUM_OPS    = opl3_pkg::NUM_OPERATORS_PER_BANK,
    parameter int unsigned OP_SPACING = opl3_pkg::OP_ISSUE_SPACING,
    parameter int unsigned PIPE_DELAY = opl3_pkg::PHASE_PIPE_DELAY
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_sample_clk_en,
    input  logic                                i_ovr_clr,
    output logic [opl3_pkg::BANK_NUM_WIDTH-1:0] o_bank_num,
    output logic [opl3_pkg::OP_NUM_WIDTH-1:0]   o_op_num,
    output logic                                o_issue_p0,
    output logic [opl3_pkg::BANK_NUM_WIDTH-1:0] o_bank_num_p2,
    output logic [opl3_pkg::OP_NUM_WIDTH-1:0]   o_op_num_p2,
    output logic                                o_valid_p2,
    output logic                                o_busy,
    output logic                                o_sweep_done,
    output logic                                o_overrun
);

    import opl3_pkg::*;

    localparam int unsigned GAP_W   = cnt_width(OP_SPACING);
    localparam int unsigned DRAIN_W = cnt_width(PIPE_DELAY);

    localparam int unsigned GAP_LAST_INT = (OP_SPACING > 1) ? OP_SPACING - 2 : 0;

    localparam logic [BANK_NUM_WIDTH-1:0] LAST_BANK  = BANK_NUM_WIDTH'(NUM_BANKS - 1);
    localparam logic [OP_NUM_WIDTH-1:0]   LAST_OP    = OP_NUM_WIDTH'(NUM_OPS - 1);
    localparam logic [GAP_W-1:0]          GAP_LAST   = GAP_W'(GAP_LAST_INT);
    localparam logic [DRAIN_W-1:0]        DRAIN_LAST = DRAIN_W'(PIPE_DELAY - 1);

    seq_state_t                r_state;
    seq_state_t                w_state_next;
    logic [BANK_NUM_WIDTH-1:0] r_bank;
    logic [BANK_NUM_WIDTH-1:0] w_bank_next;
    logic [OP_NUM_WIDTH-1:0]   r_op;
    logic [OP_NUM_WIDTH-1:0]   w_op_next;
    logic [GAP_W-1:0]          r_gap_cnt;
    logic [GAP_W-1:0]          w_gap_cnt_next;
    logic [DRAIN_W-1:0]        r_drain_cnt;
    logic [DRAIN_W-1:0]        w_drain_cnt_next;
    logic                      r_overrun;

    logic w_issue;
    logic w_advance;
    logic w_last_slot;
    logic w_busy;
    logic w_sweep_done;

    assign w_busy      = (r_state != IDLE);
    assign w_last_slot = (r_bank == LAST_BANK) && (r_op == LAST_OP);

    // r_bank/r_op always name the slot being issued or the one issued last, so
    // the register-file address only changes in the cycle a new slot issues.
    always_comb begin
        w_state_next     = r_state;
        w_bank_next      = r_bank;
        w_op_next        = r_op;
        w_gap_cnt_next   = r_gap_cnt;
        w_drain_cnt_next = r_drain_cnt;
        w_issue          = 1'b0;
        w_advance        = 1'b0;
        w_sweep_done     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (i_sample_clk_en) begin
                    w_state_next = ISSUE;
                    w_bank_next  = '0;
                    w_op_next    = '0;
                end
            end
            ISSUE: begin
                w_issue = 1'b1;
                if (w_last_slot) begin
                    w_state_next     = DRAIN;
                    w_drain_cnt_next = '0;
                end else if (OP_SPACING > 1) begin
                    w_state_next   = GAP;
                    w_gap_cnt_next = '0;
                end else begin
                    w_state_next = ISSUE;
                    w_advance    = 1'b1;
                end
            end
            GAP: begin
                // OP_SPACING-1 gap cycles: counter runs 0..OP_SPACING-2.
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = ISSUE;
                    w_advance    = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
                end
            end
            DRAIN: begin
                // Last DRAIN cycle coincides with the final slot's valid_p2.
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_sweep_done = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_drain_cnt_next = r_drain_cnt + DRAIN_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_advance) begin
            if (r_op == LAST_OP) begin
                w_op_next   = '0;
                w_bank_next = r_bank + BANK_NUM_WIDTH'(1);
            end else begin
                w_op_next = r_op + OP_NUM_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_bank      <= '0;
            r_op        <= '0;
            r_gap_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_bank      <= w_bank_next;
            r_op        <= w_op_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    // A start request that arrives while busy wins over a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overrun <= 1'b0;
        end else if (i_sample_clk_en && w_busy) begin
            r_overrun <= 1'b1;
        end else if (i_ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    slot_tag_pipe #(
        .DEPTH  (PIPE_DELAY),
        .BANK_W (BANK_NUM_WIDTH),
        .OP_W   (OP_NUM_WIDTH)
    ) u_tag_pipe (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (w_issue),
        .i_bank    (r_bank),
        .i_op      (r_op),
        .o_valid   (o_valid_p2),
        .o_bank    (o_bank_num_p2),
        .o_op      (o_op_num_p2)
    );

    assign o_bank_num   = r_bank;
    assign o_op_num     = r_op;
    assign o_issue_p0   = w_issue;
    assign o_busy       = w_busy;
    assign o_sweep_done = w_sweep_done;
    assign o_overrun    = r_overrun;

endmodule
